// File: rtl/pc_gen.sv
// pc_gen: program-counter stage of the NPC multicycle core.
// Holds the architectural PC and offers it to the IFU with a valid/ready
// handshake. It then waits for the fetched instruction to commit and
// loads the next PC. A CSR trap or return redirect takes priority over
// jalr, jal and branch targets.
// Optional feature macro: PC_MISALIGN_CHECK_EN. When it is defined,
// pc_misalign is a flag that records bit[1] of each committed target.
module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            commit,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic            br_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            mpcWr,
  input  logic [XLEN-1:0] mretPc,
  output logic [31:0]     instr_cnt,
  output logic            pc_misalign
);

  typedef enum logic {
    S_ISSUE = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic [31:0]     instr_cnt_q;
  logic [XLEN-1:0] next_pc_d;
  logic [XLEN-1:0] jalr_sum;
  logic            commit_fire;

  // A commit only counts while the stage is waiting; a commit during
  // issue is ignored.
  assign commit_fire = (state_q == S_WAIT) && commit;
  assign jalr_sum    = rs1 + imm;

  // Select the next PC by priority: redirect, jalr, jal, taken branch,
  // then fall through. All adds wrap modulo 2^XLEN.
  always_comb begin
    next_pc_d = pc_q + XLEN'(4);
    if (mpcWr) begin
      next_pc_d = mretPc;
    end else if (is_jalr) begin
      next_pc_d = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_jal) begin
      next_pc_d = pc_q + imm;
    end else if (is_branch && br_taken) begin
      next_pc_d = pc_q + imm;
    end
  end

  // Issue/wait FSM. pc_valid is raised one cycle after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      instr_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (!pc_valid_q) begin
            pc_valid_q <= 1'b1;
          end else if (pc_ready) begin
            pc_valid_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (commit_fire) begin
            pc_q        <= next_pc_d;
            instr_cnt_q <= instr_cnt_q + 32'd1;
            pc_valid_q  <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        default: begin
          state_q    <= S_ISSUE;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign instr_cnt = instr_cnt_q;

`ifdef PC_MISALIGN_CHECK_EN
  logic pc_misalign_q;

  // Record whether the committed target is halfword-aligned only. The
  // target is still loaded; trapping on it is the CSR path's job.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_misalign_q <= 1'b0;
    end else if (commit_fire) begin
      pc_misalign_q <= next_pc_d[1];
    end
  end

  assign pc_misalign = pc_misalign_q;
`else
  assign pc_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. It uses a behavioural PC/count model
// together with directed and randomized fetch/commit transactions.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready = 1'b0;
  logic        commit = 1'b0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic        is_branch = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        mpcWr = 1'b0;
  logic [31:0] mretPc = '0;
  logic [31:0] instr_cnt;
  logic        pc_misalign;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_txn = 0;

  // Reference model state
  logic [31:0] pc_m;
  logic [31:0] cnt_m;
  logic        mis_m;

  pc_gen #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .commit(commit), .is_jal(is_jal), .is_jalr(is_jalr), .is_branch(is_branch),
    .br_taken(br_taken), .imm(imm), .rs1(rs1), .mpcWr(mpcWr), .mretPc(mretPc),
    .instr_cnt(instr_cnt), .pc_misalign(pc_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Architectural target rule applied directly to the instruction fields
  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic jal,
      input logic jalr, input logic br, input logic tk, input logic [31:0] imm_v,
      input logic [31:0] rs1_v, input logic mpc, input logic [31:0] mret_v);
    longint unsigned s;
    if (mpc) return mret_v;
    if (jalr) begin
      s = (longint'(rs1_v) + longint'(imm_v)) % 64'h1_0000_0000;
      return 32'(s - (s % 2));
    end
    if (jal || (br && tk)) s = (longint'(cur) + longint'(imm_v)) % 64'h1_0000_0000;
    else                   s = (longint'(cur) + 4) % 64'h1_0000_0000;
    return 32'(s);
  endfunction

  // Drive junk on the sampled-at-commit controls; the DUT must ignore it
  task automatic scramble();
    is_jal = 1'($urandom); is_jalr = 1'($urandom); is_branch = 1'($urandom);
    br_taken = 1'($urandom); imm = $urandom; rs1 = $urandom;
    mpcWr = 1'($urandom); mretPc = $urandom;
  endtask

  task automatic model_reset();
    pc_m = RESET_PC; cnt_m = 0; mis_m = 1'b0;
  endtask

  // Present pc, stall the IFU for 'stall' cycles, then accept it
  task automatic fetch(input int stall);
    int k;
    k = 0;
    while (pc_valid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check_eq("valid_timeout", 32'(pc_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      pc_ready = 1'b0;
      check_eq("stall_pc", pc, pc_m);
      check_eq("stall_valid", 32'(pc_valid), 32'd1);
      @(negedge clk);
    end
    check_eq("offer_pc", pc, pc_m);
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    check_eq("hs_valid_drop", 32'(pc_valid), 32'd0);
  endtask

  // Wait 'idle' cycles in the wait state, then commit with the given fields
  task automatic do_commit(input logic jal, input logic jalr, input logic br, input logic tk,
      input logic [31:0] imm_v, input logic [31:0] rs1_v, input logic mpc,
      input logic [31:0] mret_v, input int idle);
    logic [31:0] exp;
    for (int i = 0; i < idle; i++) begin
      scramble();
      pc_ready = 1'($urandom);
      @(negedge clk);
      check_eq("wait_pc", pc, pc_m);
      check_eq("wait_valid", 32'(pc_valid), 32'd0);
    end
    pc_ready = 1'($urandom);
    check_eq("proto_commit_in_issue", 32'(pc_valid), 32'd0);
    is_jal = jal; is_jalr = jalr; is_branch = br; br_taken = tk;
    imm = imm_v; rs1 = rs1_v; mpcWr = mpc; mretPc = mret_v;
    commit = 1'b1;
    exp = ref_target(pc_m, jal, jalr, br, tk, imm_v, rs1_v, mpc, mret_v);
    @(negedge clk);
    commit = 1'b0;
    pc_ready = 1'b0;
    scramble();
    pc_m = exp;
    cnt_m = cnt_m + 1;
`ifdef PC_MISALIGN_CHECK_EN
    mis_m = exp[1];
`else
    mis_m = 1'b0;
`endif
    n_txn++;
    check_eq("commit_pc", pc, pc_m);
    check_eq("commit_valid", 32'(pc_valid), 32'd1);
    check_eq("commit_cnt", instr_cnt, cnt_m);
    check_eq("commit_misalign", 32'(pc_misalign), 32'(mis_m));
    $display("txn %0d: mpc=%0b jalr=%0b jal=%0b br=%0b tk=%0b imm=%h rs1=%h -> pc=%h cnt=%0d mis=%0b",
             n_txn, mpc, jalr, jal, br, tk, imm_v, rs1_v, pc, instr_cnt, pc_misalign);
  endtask

  // Hold reset for n cycles, checking the reset state, then release it
  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("rst_pc", pc, RESET_PC);
      check_eq("rst_valid", 32'(pc_valid), 32'd0);
      check_eq("rst_cnt", instr_cnt, 32'd0);
      check_eq("rst_misalign", 32'(pc_misalign), 32'd0);
    end
    rst = 1'b0;
    commit = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("post_rst_valid", 32'(pc_valid), 32'd1);
    check_eq("post_rst_pc", pc, RESET_PC);
    $display("reset released: pc=%h valid=%0b", pc, pc_valid);
  endtask

  initial begin
    logic jal, jalr, br, tk, mpc;
    model_reset();
    apply_reset(3);

    // Sequential commit followed by a 4-cycle IFU stall
    fetch(0);
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
    fetch(4);

    // Control flow
    do_commit(0, 1, 0, 0, 32'h4, 32'h8000_1003, 0, 32'h0, 2);
    check_eq("jalr_target", pc, 32'h8000_1006);
    fetch(1);
    do_commit(0, 0, 1, 1, 32'hFFFF_FFF8, 32'h0, 0, 32'h0, 0);
    check_eq("branch_taken", pc, 32'h8000_0FFE);
    fetch(0);
    do_commit(0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0, 0, 32'h0, 1);
    check_eq("branch_not_taken", pc, 32'h8000_1002);
    fetch(2);

    // Trap redirect outranks jal, then mret
    do_commit(1, 0, 0, 0, 32'h40, 32'h0, 1, 32'h8000_0100, 0);
    check_eq("trap_priority", pc, 32'h8000_0100);
    fetch(0);
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h8000_0010, 1);
    check_eq("mret_target", pc, 32'h8000_0010);
    fetch(0);

    // Address wrap
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    fetch(0);
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    check_eq("wrap_pc", pc, 32'h0);

    // Reset while pc is offered but stalled
    pc_ready = 1'b0;
    @(negedge clk);
    apply_reset(1);

    // Reset coincident with a commit in the wait state
    fetch(0);
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    fetch(0);
    is_jal = 1'b1; imm = 32'h100; commit = 1'b1;
    apply_reset(2);
    fetch(0);
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    check_eq("after_rst_cnt", instr_cnt, 32'd1);
    fetch(0);

`ifdef PC_MISALIGN_CHECK_EN
    apply_reset(1);
    fetch(0);
    do_commit(1, 0, 0, 0, 32'h6, 32'h0, 0, 32'h0, 0);
    check_eq("mis_set", 32'(pc_misalign), 32'd1);
    fetch(0);
    do_commit(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    check_eq("mis_hold_pc", pc, 32'h8000_000A);
    check_eq("mis_hold", 32'(pc_misalign), 32'd1);
    fetch(0);
    do_commit(1, 0, 0, 0, 32'h2, 32'h0, 0, 32'h0, 0);
    check_eq("mis_clear", 32'(pc_misalign), 32'd0);
    fetch(0);
`endif

    // Randomized transactions
    for (int t = 0; t < 150; t++) begin
      mpc  = ($urandom_range(0, 7) == 0);
      jalr = ($urandom_range(0, 3) == 0);
      jal  = ($urandom_range(0, 3) == 0);
      br   = ($urandom_range(0, 2) == 0);
      tk   = 1'($urandom);
      do_commit(jal, jalr, br, tk, $urandom, $urandom, mpc, $urandom, $urandom_range(0, 3));
      fetch($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
